// File: rtl/memory_array_ctrl.sv
// DEPTH x WIDTH storage array behind a single valid/ready request port.
// Supports read, write and clear-all; a hardware sweep zeroes every row after reset or clear.
module memory_array_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             err
);

  typedef enum logic {ST_CLR, ST_IDLE} state_t;

  localparam logic [1:0]    OP_RD    = 2'b00;
  localparam logic [1:0]    OP_WR    = 2'b01;
  localparam logic [1:0]    OP_CLR   = 2'b10;
  // One extra bit so DEPTH == 2**AW is still representable in the range compare.
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic accept;
  logic addr_ok;

  assign req_ready   = (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign addr_ok     = ({1'b0, addr} < DEPTH_X);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign err         = err_q;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = addr;
    mem_wdata     = wdata;
    case (state_q)
      ST_CLR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == LAST_ROW) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          case (op)
            OP_RD: begin
              if (addr_ok) begin
                rdata_d       = mem[addr];
                rdata_valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_WR: begin
              if (addr_ok) begin
                mem_we = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLR: begin
              state_d   = ST_CLR;
              clr_cnt_d = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_CLR;
      clr_cnt_q     <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  // Storage has no reset of its own; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_memory_array_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model,
// and a second DEPTH=3 instance for out-of-range addressing.
module tb_memory_array_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] op;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       err;

  logic       v3;
  logic       ready3;
  logic [1:0] op3;
  logic [1:0] a3;
  logic [7:0] wd3;
  logic [7:0] rdata3;
  logic       rv3;
  logic       err3;

  always #5 clk = ~clk;

  memory_array_ctrl #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err)
  );

  memory_array_ctrl #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(ready3),
    .op(op3), .addr(a3), .wdata(wd3), .rdata(rdata3),
    .rdata_valid(rv3), .err(err3)
  );

  // Reference model: row contents, remaining busy cycles, expected outputs.
  logic [7:0] m [DEPTH];
  int         busy;
  logic       exp_ready;
  logic [7:0] exp_rdata;
  logic       exp_rv;
  logic       exp_err;

  int total  = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic step();
    bit acc;
    acc = rst_n && req_valid && exp_ready;
    @(posedge clk);
    cyc++;
    exp_rv  = 1'b0;
    exp_err = 1'b0;
    if (!rst_n) begin
      busy      = DEPTH;
      exp_rdata = 8'h00;
      for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
    end else if (busy > 0) begin
      busy--;
    end else if (acc) begin
      if (op == 2'd3 || (op != 2'd2 && int'(addr) >= DEPTH)) begin
        exp_err = 1'b1;
      end else if (op == 2'd0) begin
        exp_rdata = m[addr];
        exp_rv    = 1'b1;
      end else if (op == 2'd1) begin
        m[addr] = wdata;
      end else begin
        busy = DEPTH;
        for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
      end
    end
    exp_ready = (busy == 0);
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
    chk("err", 32'(err), 32'(exp_err));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    $display("cyc=%0d rst_n=%0b v=%0b op=%0d addr=%0d wd=%02h | rdy=%0b rv=%0b err=%0b rdata=%02h",
             cyc, rst_n, req_valid, op, addr, wdata, req_ready, rdata_valid, err, rdata);
  endtask

  task automatic req(input logic [1:0] o, input logic [1:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    wdata     = d;
    step();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; op = 2'd0; addr = 2'd0; wdata = 8'h00;
    v3 = 1'b0; op3 = 2'd0; a3 = 2'd0; wd3 = 8'h00;
    busy = DEPTH; exp_ready = 1'b0; exp_rdata = 8'h00; exp_rv = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;

    // Reset, then sweep: ready low for DEPTH cycles.
    step(); step();
    rst_n = 1'b1;
    idle(DEPTH + 1);
    for (int r = 0; r < DEPTH; r++) req(2'd0, 2'(r), 8'h00);
    idle(1);

    // Write then read same row; rdata holds when idle.
    req(2'd1, 2'd2, 8'hAA);
    req(2'd0, 2'd2, 8'h00);
    idle(2);

    // Back-to-back write/read.
    req(2'd1, 2'd1, 8'hCC);
    req(2'd0, 2'd1, 8'h00);
    req(2'd1, 2'd1, 8'h33);
    req(2'd0, 2'd1, 8'h00);
    idle(1);

    // Last valid row and reserved op.
    req(2'd0, 2'd3, 8'h00);
    req(2'd1, 2'd3, 8'hFF);
    req(2'd3, 2'd0, 8'h00);
    req(2'd0, 2'd3, 8'h00);
    idle(1);

    // Clear with a read held on the port throughout the sweep.
    req(2'd1, 2'd0, 8'h11);
    req(2'd1, 2'd1, 8'h22);
    req(2'd1, 2'd2, 8'h33);
    req(2'd1, 2'd3, 8'h44);
    req(2'd2, 2'd0, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) req(2'd0, 2'd1, 8'h00);
    idle(1);

    // Reset pulse during the second cycle of a clear sweep.
    req(2'd1, 2'd2, 8'h5A);
    req(2'd2, 2'd0, 8'h00);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(DEPTH + 1);
    for (int r = 0; r < DEPTH; r++) req(2'd0, 2'(r), 8'h00);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel       = int'($urandom_range(0, 15));
      req_valid = ($urandom_range(0, 3) != 0);
      op        = (sel < 7) ? 2'd0 : (sel < 14) ? 2'd1 : (sel == 14) ? 2'd3 : 2'd2;
      addr      = 2'($urandom_range(0, 3));
      wdata     = 8'($urandom_range(0, 255));
      step();
    end
    idle(DEPTH + 1);

    // DEPTH=3 instance: address 3 is out of range.
    v3 = 1'b1; op3 = 2'd1; a3 = 2'd1; wd3 = 8'h5A;
    step();
    chk("d3_ready", 32'(ready3), 32'd1);
    chk("d3_wr_err", 32'(err3), 32'd0);
    op3 = 2'd0; a3 = 2'd1;
    step();
    chk("d3_rd_rv", 32'(rv3), 32'd1);
    chk("d3_rd_data", 32'(rdata3), 32'h5A);
    op3 = 2'd0; a3 = 2'd3;
    step();
    chk("d3_oor_rd_err", 32'(err3), 32'd1);
    chk("d3_oor_rd_rv", 32'(rv3), 32'd0);
    chk("d3_oor_rd_data", 32'(rdata3), 32'h5A);
    op3 = 2'd1; a3 = 2'd3; wd3 = 8'hEE;
    step();
    chk("d3_oor_wr_err", 32'(err3), 32'd1);
    op3 = 2'd0; a3 = 2'd2;
    step();
    chk("d3_row2_rv", 32'(rv3), 32'd1);
    chk("d3_row2_data", 32'(rdata3), 32'h00);
    chk("d3_row2_err", 32'(err3), 32'd0);
    v3 = 1'b0;
    step();
    chk("d3_idle_rv", 32'(rv3), 32'd0);
    chk("d3_idle_err", 32'(err3), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
